// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO, with rollback and interrupt gating.
// Optional multiply-accumulate ops are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             IntReq,
    input  logic             Rollback,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy
);
    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
    localparam logic [3:0] OP_MADD  = 4'b1000;
    localparam logic [3:0] OP_MADDU = 4'b1001;
    localparam logic [3:0] OP_MSUB  = 4'b1010;
    localparam logic [3:0] OP_MSUBU = 4'b1011;

    logic [WIDTH-1:0] hi_r, lo_r, save_hi_r, save_lo_r, a_r, b_r;
    logic [3:0]       op_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic             op_valid_s, op_md_s, accept_s;
    logic [CNT_W-1:0] op_lat_s;

    // Decode the incoming opcode: validity, multi-cycle class and latency.
    always_comb begin
        op_valid_s = 1'b0;
        op_md_s    = 1'b0;
        op_lat_s   = CNT_ZERO;
        case (Op)
            OP_MULT, OP_MULTU: begin
                op_valid_s = 1'b1;
                op_md_s    = 1'b1;
                op_lat_s   = MULT_LAT;
            end
            OP_DIV, OP_DIVU: begin
                op_valid_s = 1'b1;
                op_md_s    = 1'b1;
                op_lat_s   = DIV_LAT;
            end
            OP_MTHI, OP_MTLO: begin
                op_valid_s = 1'b1;
            end
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                op_valid_s = 1'b1;
                op_md_s    = 1'b1;
                op_lat_s   = MULT_LAT;
            end
`endif
            default: begin
                op_valid_s = 1'b0;
                op_md_s    = 1'b0;
                op_lat_s   = CNT_ZERO;
            end
        endcase
    end

    assign accept_s = Start & ~busy_r & ~IntReq & ~Rollback & op_valid_s;

    // Odd opcodes are the unsigned variants in every class.
    logic                 sgn_s, a_neg_s, b_neg_s, b_zero_s;
    logic [2*WIDTH-1:0]   a_ext_s, b_ext_s, product_s, result_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s, divisor_s, q_mag_s, r_mag_s, quo_s, rem_s;

    // Arithmetic on the latched operands; divide works on magnitudes then re-signs.
    always_comb begin
        sgn_s     = ~op_r[0];
        a_ext_s   = {{WIDTH{sgn_s & a_r[WIDTH-1]}}, a_r};
        b_ext_s   = {{WIDTH{sgn_s & b_r[WIDTH-1]}}, b_r};
        product_s = a_ext_s * b_ext_s;
        a_neg_s   = sgn_s & a_r[WIDTH-1];
        b_neg_s   = sgn_s & b_r[WIDTH-1];
        a_mag_s   = a_neg_s ? (~a_r + ONE) : a_r;
        b_mag_s   = b_neg_s ? (~b_r + ONE) : b_r;
        b_zero_s  = (b_r == {WIDTH{1'b0}});
        divisor_s = b_zero_s ? ONE : b_mag_s;
        q_mag_s   = a_mag_s / divisor_s;
        r_mag_s   = a_mag_s % divisor_s;
        quo_s     = (a_neg_s ^ b_neg_s) ? (~q_mag_s + ONE) : q_mag_s;
        rem_s     = a_neg_s ? (~r_mag_s + ONE) : r_mag_s;
        case (op_r)
            OP_MULT, OP_MULTU: result_s = product_s;
            OP_DIV, OP_DIVU: begin
                if (b_zero_s) begin
                    result_s = {a_r, {WIDTH{1'b1}}};
                end else begin
                    result_s = {rem_s, quo_s};
                end
            end
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU: result_s = {hi_r, lo_r} + product_s;
            OP_MSUB, OP_MSUBU: result_s = {hi_r, lo_r} - product_s;
`endif
            default: result_s = {hi_r, lo_r};
        endcase
    end

    // Sequencing: rollback outranks completion and issue; completion writes on the 1->0 count.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            save_hi_r <= {WIDTH{1'b0}};
            save_lo_r <= {WIDTH{1'b0}};
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            op_r      <= 4'b0000;
            cnt_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
        end else if (Rollback) begin
            hi_r   <= save_hi_r;
            lo_r   <= save_lo_r;
            cnt_r  <= CNT_ZERO;
            busy_r <= 1'b0;
        end else if (accept_s) begin
            save_hi_r <= hi_r;
            save_lo_r <= lo_r;
            a_r       <= A;
            b_r       <= B;
            op_r      <= Op;
            if (Op == OP_MTHI) hi_r <= A;
            if (Op == OP_MTLO) lo_r <= A;
            if (op_md_s) begin
                cnt_r  <= op_lat_s;
                busy_r <= 1'b1;
            end
        end else if (busy_r) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
                busy_r       <= 1'b0;
                {hi_r, lo_r} <= result_s;
            end
        end
    end

    assign HI   = hi_r;
    assign LO   = lo_r;
    assign Busy = busy_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (default parameters).
module tb_muldiv_unit;
    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
    localparam logic [3:0] OP_MADD  = 4'b1000;

    logic        clk = 1'b0;
    logic        reset, Start, IntReq, Rollback, Busy;
    logic [3:0]  Op;
    logic [31:0] A, B, HI, LO;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_busy;

    muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .IntReq(IntReq), .Rollback(Rollback), .HI(HI), .LO(LO), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_rollback();
        Rollback = 1'b1;
        @(negedge clk);
        Rollback = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; IntReq = 1'b0; Rollback = 1'b0;
        Op = 4'b0000; A = 32'h0; B = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_hi", 64'(HI), 64'h0);
        check_eq("rst_lo", 64'(LO), 64'h0);
        check_eq("rst_busy", 64'(Busy), 64'h0);

        pulse_rollback();
        check_eq("rb_empty", {HI, LO}, 64'h0);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_idle(n_busy);
        check_eq("mult_lat", 64'(n_busy), 64'd5);
        check_eq("mult_res", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle(n_busy);
        check_eq("divu_lat", 64'(n_busy), 64'd10);
        check_eq("divu_res", {HI, LO}, {32'd2, 32'd14});

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n_busy);
        check_eq("div_neg", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        issue(OP_DIV, 32'h1234_5678, 32'h0);
        wait_idle(n_busy);
        check_eq("div_zero", {HI, LO}, {32'h1234_5678, 32'hFFFF_FFFF});

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n_busy);
        check_eq("div_ovf", {HI, LO}, {32'h0, 32'h8000_0000});

        // Abort an in-flight multiply on its third cycle.
        issue(OP_MTHI, 32'h11, 32'h0);
        issue(OP_MTLO, 32'h22, 32'h0);
        check_eq("mt_busy", 64'(Busy), 64'h0);
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (2) @(negedge clk);
        pulse_rollback();
        check_eq("rb_busy", 64'(Busy), 64'h0);
        check_eq("rb_hilo", {HI, LO}, {32'h11, 32'h22});
        repeat (8) @(negedge clk);
        check_eq("rb_nowrite", {HI, LO}, {32'h11, 32'h22});

        @(negedge clk);
        IntReq = 1'b1; Start = 1'b1; Op = OP_MTHI; A = 32'hAB;
        @(negedge clk);
        IntReq = 1'b0; Start = 1'b0;
        check_eq("intreq_blk", 64'(HI), 64'h11);
        issue(OP_MTHI, 32'hAB, 32'h0);
        check_eq("mthi_hi", 64'(HI), 64'hAB);
        check_eq("mthi_busy", 64'(Busy), 64'h0);

        issue(OP_DIVU, 32'd100, 32'd7);
        Start = 1'b1; Op = OP_MTLO; A = 32'h55;
        @(negedge clk);
        Start = 1'b0;
        wait_idle(n_busy);
        check_eq("start_busy", {HI, LO}, {32'd2, 32'd14});

        pulse_rollback();
        check_eq("rb_done", {HI, LO}, {32'hAB, 32'h22});

        // Rollback coinciding with the completing edge wins.
        issue(OP_MULT, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        pulse_rollback();
        check_eq("rb_cmpl_busy", 64'(Busy), 64'h0);
        check_eq("rb_cmpl", {HI, LO}, {32'hAB, 32'h22});

        issue(4'b0111, 32'd99, 32'd1);
        check_eq("bad_op_busy", 64'(Busy), 64'h0);
        check_eq("bad_op", {HI, LO}, {32'hAB, 32'h22});

        issue(OP_MTHI, 32'h0, 32'h0);
        issue(OP_MTLO, 32'd10, 32'h0);
        issue(OP_MADD, 32'd2, 32'd3);
`ifdef MULDIV_MADD_EN
        wait_idle(n_busy);
        check_eq("madd_lat", 64'(n_busy), 64'd5);
        check_eq("madd_res", {HI, LO}, {32'h0, 32'd16});
`else
        check_eq("madd_busy", 64'(Busy), 64'h0);
        repeat (6) @(negedge clk);
        check_eq("madd_off", {HI, LO}, {32'h0, 32'd10});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair; sits in the Execution stage beside the ALU.
- Accepts one operation per Start pulse and stalls the pipeline via Busy.
- Supports interrupt suppression and rollback of HI/LO.
- Generalises the fixed 32-bit mult/div unit with configurable width, per-class latency, division corner-case rules and an optional multiply-accumulate mode.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, multiply latency in cycles; minimum 1.
- DIV_CYCLES, 10, divide latency in cycles; minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  issue strobe, sampled at clk edge.
- Op  input  4  operation code, valid with Start.
- A  input  WIDTH  rs operand (forwarded).
- B  input  WIDTH  rt operand (forwarded).
- IntReq  input  1  exception/interrupt taken this cycle.
- Rollback  input  1  the last accepted op is being flushed.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.
- Busy  output  1  operation in flight (registered).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: HI=0, LO=0, Busy=0. Counter, saved HI/LO and latched operands are also 0.
- Op codes:
  - 0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MTHI, 0101 MTLO.
  - 1000 MADD, 1001 MADDU, 1010 MSUB, 1011 MSUBU (feature only).
  - All other codes: no effect.
- Acceptance: Start accepted only when Busy=0, IntReq=0, Rollback=0 and Op is valid. Otherwise ignored, with no state change.
- On acceptance:
  - Current HI/LO copied to the saved registers.
  - A, B and Op latched.
- MTHI/MTLO: HI (or LO) := A at the accepting edge. No Busy.
- Mult/div timing:
  - Counter loaded with MULT_CYCLES or DIV_CYCLES at the accepting edge.
  - Busy=1 while counter≠0; counter decrements each cycle.
  - On the 1→0 transition, HI/LO are written with the result and Busy falls at that same edge.
  - Busy is therefore high for exactly LAT cycles.
  - New HI/LO are visible on the cycle after the last Busy cycle.
- Hazard handling: the pipeline stalls on (Start & mult/div op) | Busy, which the hazard unit forms. The unit never accepts during Busy.
- Multiply: full 2·WIDTH product. HI = upper half, LO = lower half. Signed ops (MULT, DIV) treat A and B as two's complement; unsigned ops zero-extend.
- Divide:
  - LO = quotient, truncated toward zero; HI = remainder, which carries the sign of the dividend.
  - B=0: LO = all ones, HI = A.
  - Signed MIN/−1: LO = MIN, HI = 0.
- Rollback (highest priority):
  - Aborts any in-flight op: counter→0, Busy→0 next edge, no completion write.
  - Restores HI/LO from the saved registers. This also undoes a completed op or an MTHI/MTLO.
  - Beats a simultaneous completion and a simultaneous Start.
  - Rollback before any accepted op restores 0/0.
- IntReq: blocks acceptance only. An in-flight op continues and completes normally unless Rollback is asserted.
- reset mid-operation: everything returns to reset values at that edge; no completion write.
- WIDTH arithmetic: results are computed on the latched operands, so A/B changes during Busy have no effect.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined:
  - Ops 1000–1011 are valid and use MULT_CYCLES latency.
  - At completion: {HI,LO} := {HI,LO} ± product, mod 2^(2·WIDTH). Signed for MADD/MSUB, unsigned for MADDU/MSUBU.
  - {HI,LO} is the value at completion time.
- Undefined: codes 1000–1011 are invalid and ignored (no Busy, no state change); accumulate logic is absent.

Test Plan:
- MULT A=0xFFFFFFFD (−3), B=5 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU A=100, B=7 -> Busy 10 cycles; LO=14, HI=2. DIV A=−7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV by zero with A=0x12345678 -> LO=0xFFFFFFFF, HI=0x12345678. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- HI=0x11, LO=0x22; MULTU 3×4 issued; Rollback on cycle 3 -> Busy drops next edge; HI=0x11, LO=0x22; no later write.
- Start (MTHI A=0xAB) with IntReq=1 -> HI unchanged. Retry with IntReq=0 -> HI=0xAB the next cycle, Busy stays 0. Start during Busy -> ignored.
- With MULDIV_MADD_EN: HI=0, LO=10; MADD 2×3 -> LO=16 after 5 cycles. Without the macro: same stimulus -> Busy stays 0, LO=10.
